// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared constants and state encoding for the serial pattern transmitter
package seq_tx_pkg;

    localparam int DEF_PAT_W = 5;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 4;

    // Sequence flagged by the 5-state detector
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

endpackage

// File: rtl/seq_tx_shift.sv
// rtl/seq_tx_shift.sv - load/shift-left pattern register with bit-index down counter
module seq_tx_shift #(
    parameter int PAT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    output logic             msb,
    output logic             last_bit
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sh_q;
    logic [IDX_W-1:0] idx_q;

    // Shifting in zeros means the register is all-zero once a copy has fully
    // drained, so msb doubles as the idle-low serial output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            sh_q  <= pattern;
            idx_q <= IDX_W'(PAT_W - 1);
        end else if (shift) begin
            sh_q <= {sh_q[PAT_W-2:0], 1'b0};
            if (idx_q != '0)
                idx_q <= idx_q - 1'b1;
        end
    end

    assign msb      = sh_q[PAT_W-1];
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with repeat count and inter-copy gap
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] DEF_PAT = DEF_PATTERN,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter int               GAP_W   = DEF_GAP_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [PAT_W-1:0] PATTERN,
    input  logic [CNT_W-1:0] REPEAT,
    input  logic [GAP_W-1:0] GAP,
    output logic             DOUT,
    output logic             DVALID,
    output logic             FRAME_START,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] copy_q, copy_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             dvalid_q, dvalid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sh_load, sh_shift;
    logic [PAT_W-1:0] sh_pattern;
    logic             sh_msb, sh_last;

    seq_tx_shift #(.PAT_W(PAT_W)) u_shift (
        .CLK      (CLK),
        .RST      (RST),
        .load     (sh_load),
        .shift    (sh_shift),
        .pattern  (sh_pattern),
        .msb      (sh_msb),
        .last_bit (sh_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pat_q    <= '0;
            gap_q    <= '0;
            copy_q   <= '0;
            gcnt_q   <= '0;
            dvalid_q <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            gap_q    <= gap_d;
            copy_q   <= copy_d;
            gcnt_q   <= gcnt_d;
            dvalid_q <= dvalid_d;
            fs_q     <= fs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Output flags are computed for the cycle being entered, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        gap_d      = gap_q;
        copy_d     = copy_q;
        gcnt_d     = gcnt_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_pattern = pat_q;
        dvalid_d   = 1'b0;
        fs_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    pat_d      = (PATTERN == '0) ? DEF_PAT : PATTERN;
                    gap_d      = GAP;
                    copy_d     = REPEAT;
                    sh_pattern = pat_d;
                    sh_load    = 1'b1;
                    state_d    = ST_SEND;
                    dvalid_d   = 1'b1;
                    fs_d       = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_SEND: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                    dvalid_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (copy_q != '0) begin
                    copy_d = copy_q - 1'b1;
                    busy_d = 1'b1;
                    if (gap_q == '0) begin
                        sh_load  = 1'b1;
                        dvalid_d = 1'b1;
                        fs_d     = 1'b1;
                    end else begin
                        sh_shift = 1'b1;
                        gcnt_d   = gap_q;
                        state_d  = ST_GAP;
                    end
                end else begin
                    sh_shift = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                gcnt_d = gcnt_q - 1'b1;
                if (gcnt_q == GAP_W'(1)) begin
                    sh_load  = 1'b1;
                    dvalid_d = 1'b1;
                    fs_d     = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DOUT        = sh_msb;
    assign DVALID      = dvalid_q;
    assign FRAME_START = fs_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx against a cycle-list model
module tb_seq_pattern_tx;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [4:0] PATTERN;
    logic [3:0] REPEAT;
    logic [3:0] GAP;
    logic       DOUT;
    logic       DVALID;
    logic       FRAME_START;
    logic       BUSY;
    logic       DONE;

    int tests_run;
    int tests_failed;

    // Expected per-cycle {DOUT, DVALID, FRAME_START, BUSY, DONE}, starting the cycle after START
    logic [4:0]  exp_q[$];
    logic [31:0] rx_bits;

    seq_pattern_tx dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .PATTERN     (PATTERN),
        .REPEAT      (REPEAT),
        .GAP         (GAP),
        .DOUT        (DOUT),
        .DVALID      (DVALID),
        .FRAME_START (FRAME_START),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4:0] outs();
        return {DOUT, DVALID, FRAME_START, BUSY, DONE};
    endfunction

    task automatic build_exp(input logic [4:0] pat, input int rep, input int gap);
        logic [4:0] p;
        p = (pat == 5'd0) ? 5'b10011 : pat;
        exp_q.delete();
        for (int c = 0; c <= rep; c++) begin
            for (int i = 4; i >= 0; i--)
                exp_q.push_back({p[i], 1'b1, (i == 4), 1'b1, 1'b0});
            if (c < rep)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endtask

    task automatic check_idle(input string name, input int cycles);
        logic [4:0] obs;
        for (int k = 0; k < cycles; k++) begin
            obs = outs();
            tests_run++;
            if (obs !== 5'b00000) begin
                tests_failed++;
                $display("FAIL %s cyc %0d: got %b want 00000", name, k, obs);
            end
            @(negedge CLK);
        end
    endtask

    // mode 0: quiet inputs; 1: random START pulses while busy/FIN; 2: pulse at t+3 and during FIN
    task automatic run_xfer(input string name, input logic [4:0] pat, input int rep,
                            input int gap, input int mode);
        logic [4:0] obs;
        logic       pulse;
        build_exp(pat, rep, gap);
        rx_bits = '0;
        START   = 1'b1;
        PATTERN = pat;
        REPEAT  = 4'(rep);
        GAP     = 4'(gap);
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            obs = outs();
            tests_run++;
            if (obs !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL %s cyc t+%0d: got %b want %b", name, k + 1, obs, exp_q[k]);
            end
            if (DVALID)
                rx_bits = {rx_bits[30:0], DOUT};
            if (k < exp_q.size() - 1) begin
                PATTERN = 5'($urandom);
                REPEAT  = 4'($urandom);
                GAP     = 4'($urandom);
                case (mode)
                    1:       pulse = 1'($urandom);
                    2:       pulse = (k == 2) || exp_q[k][0];
                    default: pulse = 1'b0;
                endcase
                START = pulse & (exp_q[k][1] | exp_q[k][0]);
                @(negedge CLK);
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        @(negedge CLK);
        obs = outs();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_held: got %b want 00000", obs);
        end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        obs = outs();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: got %b want 00000", obs);
        end
        @(negedge CLK);
        RST = 1'b0;
        check_idle("reset_release", 10);
    endtask

    task automatic test_default_single();
        run_xfer("default_single", 5'd0, 0, 0, 0);
        tests_run++;
        if (rx_bits[4:0] !== 5'b10011) begin
            tests_failed++;
            $display("FAIL detector_seq: got %b want 10011", rx_bits[4:0]);
        end
    endtask

    task automatic test_repeat_gap();
        run_xfer("repeat_gap", 5'b11010, 2, 3, 0);
    endtask

    task automatic test_back_to_back();
        run_xfer("back_to_back", 5'b10110, 1, 0, 0);
    endtask

    task automatic test_ignored_start();
        run_xfer("ignored_start", 5'b01101, 1, 2, 2);
        // START in the IDLE cycle right after DONE must be accepted
        run_xfer("start_after_done", 5'b11001, 0, 0, 0);
    endtask

    task automatic test_abort();
        logic [4:0] obs;
        build_exp(5'b10101, 1, 0);
        START   = 1'b1;
        PATTERN = 5'b10101;
        REPEAT  = 4'd1;
        GAP     = 4'd0;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = outs();
            tests_run++;
            if (obs !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL abort_pre cyc t+%0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
            if (k < 2)
                @(negedge CLK);
        end
        RST = 1'b1;
        #1;
        obs = outs();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL abort_async: got %b want 00000", obs);
        end
        @(negedge CLK);
        check_idle("abort_hold", 2);
        RST = 1'b0;
        check_idle("abort_no_done", 6);
        run_xfer("after_abort", 5'b01011, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [4:0] pat;
        int         rep;
        int         gap;
        for (int n = 0; n < 8; n++) begin
            pat = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rep = $urandom_range(0, 3);
            gap = $urandom_range(0, 3);
            run_xfer("random", pat, rep, gap, 1);
        end
    endtask

    task automatic test_max_counts();
        run_xfer("max_counts", 5'b10001, 15, 15, 1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST     = 1'b1;
        START   = 1'b0;
        PATTERN = '0;
        REPEAT  = '0;
        GAP     = '0;
        rx_bits = '0;
        test_reset();
        test_default_single();
        test_repeat_gap();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        test_random();
        test_max_counts();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
